// File: rtl/lsu_subword.sv
// Load/store unit ahead of a word-addressed data memory: lane select and extend for loads,
// one-cycle word stores, two-cycle read-modify-write for sb/sh. Optional trap: LSU_MISALIGN_TRAP_EN.
module lsu_subword #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  stall,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  misalign,
    output logic [31:0]           err_addr
);
    if (DATA_WIDTH != 32 || ADDR_WIDTH < 1 || ADDR_WIDTH > 30) begin : g_bad_cfg
        $error("lsu_subword supports DATA_WIDTH = 32 and ADDR_WIDTH in 1..30 only");
    end

    typedef enum logic {IDLE, RMW} state_t;

    state_t      state;
    logic [31:0] merge_q;
    logic [31:0] cap_addr;
    logic        bad;
    logic        is_word;
    logic        is_load;
    logic        is_store;
    logic [4:0]  lane_shift;
    logic [4:0]  half_shift;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;
    logic [31:0] merged;

    // Size 11 is reserved and behaves as a word access.
    assign is_word  = req_size[1];
    assign is_load  = req_valid && !req_we && !bad && (state == IDLE);
    assign is_store = req_valid &&  req_we && !bad && (state == IDLE);

    assign lane_shift = {req_addr[1:0], 3'b000};
    assign half_shift = {req_addr[1], 4'b0000};
    assign byte_v     = 8'(mem_rdata >> lane_shift);
    assign half_v     = 16'(mem_rdata >> half_shift);

    assign lane_mask = (req_size == 2'b00) ? (32'h0000_00ff << lane_shift)
                                           : (32'h0000_ffff << half_shift);
    assign lane_data = (req_size == 2'b00) ? ({24'h0, req_wdata[7:0]} << lane_shift)
                                           : ({16'h0, req_wdata[15:0]} << half_shift);
    assign merged    = (mem_rdata & ~lane_mask) | (lane_data & lane_mask);

    assign mem_we    = !reset && ((state == RMW) || (is_store && is_word));
    assign stall     = !reset && is_store && !is_word;
    assign mem_addr  = (state == RMW) ? cap_addr : {req_addr[31:2], 2'b00};
    assign mem_wdata = (state == RMW) ? merge_q : req_wdata;

    always_comb begin
        // NOTE: rdata gets a default before the case so no path leaves it unassigned,
        // which would otherwise infer a latch.
        rdata = '0;
        if (is_load) begin
            case (req_size)
                2'b00:   rdata = {{24{!req_unsigned && byte_v[7]}}, byte_v};
                2'b01:   rdata = {{16{!req_unsigned && half_v[15]}}, half_v};
                default: rdata = mem_rdata;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            merge_q  <= '0;
            cap_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_store && !is_word) begin
                        merge_q  <= merged;
                        cap_addr <= {req_addr[31:2], 2'b00};
                        state    <= RMW;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign_q;
    logic [31:0] err_addr_q;

    assign bad = req_valid && (state == IDLE) &&
                 (((req_size == 2'b01) && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00)));

    // Sticky flag; only the first offending address is kept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_q <= 1'b0;
            err_addr_q <= '0;
        end else if (bad) begin
            misalign_q <= 1'b1;
            if (!misalign_q) err_addr_q <= req_addr;
        end
    end

    assign misalign = misalign_q;
    assign err_addr = err_addr_q;
`else
    assign bad      = 1'b0;
    assign misalign = 1'b0;
    assign err_addr = '0;
`endif

endmodule

// File: tb/tb_lsu_subword.sv
// Self-checking bench for lsu_subword: vector table plus hand sequences for RMW, reset and misalignment.
module tb_lsu_subword;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        misalign;
    logic [31:0] err_addr;

    int tests  = 0;
    int failed = 0;

    lsu_subword #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .rdata(rdata), .stall(stall),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .misalign(misalign), .err_addr(err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-addressed memory with combinational read.
    logic [31:0] mem [0:255];
    logic        mem_clr;
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        int          exp_stalls;
        int          exp_writes;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Presents one request starting just after a rising edge and holds it while stall is high.
    task automatic access(input string name, input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] exp_rd,
                          input int exp_stalls, input int exp_writes);
        int   stalls = 0;
        int   writes = 0;
        int   cyc    = 0;
        logic done   = 1'b0;
        sb_t  e;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        sb_q.push_back('{name, exp_rd});
        while (!done && cyc < 4) begin
            @(negedge clk);
            if (cyc == 0) begin
                e = sb_q.pop_front();
                check({e.name, ":rdata"}, rdata, e.exp);
            end
            if (stall)  stalls++;
            if (mem_we) writes++;
            done = !stall;
            cyc++;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            tests++;
            failed++;
            $display("FAIL %s:timeout: stall still high after %0d cycles, expected release", name, cyc);
        end
        check({name, ":stalls"}, 32'(stalls), 32'(exp_stalls));
        check({name, ":writes"}, 32'(writes), 32'(exp_writes));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int total_stalls;

        // Reset with a word store presented: nothing may reach memory.
        reset        = 1'b1;
        mem_clr      = 1'b1;
        req_valid    = 1'b1;
        req_we       = 1'b1;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 32'h10;
        req_wdata    = 32'h1234_5678;
        @(negedge clk);
        check("reset:mem_we",   {31'h0, mem_we},   32'h0);
        check("reset:stall",    {31'h0, stall},    32'h0);
        check("reset:misalign", {31'h0, misalign}, 32'h0);
        check("reset:err_addr", err_addr,          32'h0);
        @(posedge clk);
        #1;
        mem_clr   = 1'b0;
        req_valid = 1'b0;
        reset     = 1'b0;
        check("reset:no_write", mem[4], 32'h0);
        @(posedge clk);
        #1;

        vecs.push_back('{"sw_10",    1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0,         0, 1});
        vecs.push_back('{"lw_10",    1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF, 0, 0});
        vecs.push_back('{"sw_20",    1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344, 32'h0,         0, 1});
        vecs.push_back('{"sb_21",    1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_00AA, 32'h0,         1, 1});
        vecs.push_back('{"lw_20a",   1'b0, 2'b10, 1'b0, 32'h20, 32'h0,         32'h1122_AA44, 0, 0});
        vecs.push_back('{"sh_22",    1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF_5678, 32'h0,         1, 1});
        vecs.push_back('{"sb_23",    1'b1, 2'b00, 1'b0, 32'h23, 32'hFFFF_FF55, 32'h0,         1, 1});
        vecs.push_back('{"lw_20b",   1'b0, 2'b10, 1'b0, 32'h20, 32'h0,         32'h5578_AA44, 0, 0});
        vecs.push_back('{"sw_30",    1'b1, 2'b10, 1'b0, 32'h30, 32'h80FF_7F01, 32'h0,         0, 1});
        vecs.push_back('{"lb_32",    1'b0, 2'b00, 1'b0, 32'h32, 32'h0,         32'hFFFF_FFFF, 0, 0});
        vecs.push_back('{"lbu_32",   1'b0, 2'b00, 1'b1, 32'h32, 32'h0,         32'h0000_00FF, 0, 0});
        vecs.push_back('{"lh_32",    1'b0, 2'b01, 1'b0, 32'h32, 32'h0,         32'hFFFF_80FF, 0, 0});
        vecs.push_back('{"lhu_30",   1'b0, 2'b01, 1'b1, 32'h30, 32'h0,         32'h0000_7F01, 0, 0});
        vecs.push_back('{"lb_30",    1'b0, 2'b00, 1'b0, 32'h30, 32'h0,         32'h0000_0001, 0, 0});
        vecs.push_back('{"lb_31",    1'b0, 2'b00, 1'b0, 32'h31, 32'h0,         32'h0000_007F, 0, 0});
        vecs.push_back('{"lb_33",    1'b0, 2'b00, 1'b0, 32'h33, 32'h0,         32'hFFFF_FF80, 0, 0});
        vecs.push_back('{"lhu_32",   1'b0, 2'b01, 1'b1, 32'h32, 32'h0,         32'h0000_80FF, 0, 0});
        vecs.push_back('{"lh_30",    1'b0, 2'b01, 1'b0, 32'h30, 32'h0,         32'h0000_7F01, 0, 0});
        vecs.push_back('{"lrsv_30",  1'b0, 2'b11, 1'b0, 32'h30, 32'h0,         32'h80FF_7F01, 0, 0});
        vecs.push_back('{"sw_50",    1'b1, 2'b10, 1'b0, 32'h50, 32'h9988_7766, 32'h0,         0, 1});

        foreach (vecs[i])
            access(vecs[i].name, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr,
                   vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_stalls, vecs[i].exp_writes);

        // No valid request: outputs quiet even though the addressed word is non-zero.
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_size  = 2'b10;
        req_addr  = 32'h33;
        #1;
        check("idle:rdata",    rdata,             32'h0);
        check("idle:stall",    {31'h0, stall},    32'h0);
        check("idle:mem_we",   {31'h0, mem_we},   32'h0);
        check("idle:mem_addr", mem_addr,          32'h30);
        @(posedge clk);
        #1;

        // Back-to-back halfword stores into a zero word.
        total_stalls = 0;
        check("b2b:initial", mem[8'h10], 32'h0);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b01;
        req_addr  = 32'h40;
        req_wdata = 32'h0000_1234;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (stall) total_stalls++;
            @(posedge clk);
            #1;
            if (c == 1) begin
                req_addr  = 32'h42;
                req_wdata = 32'h0000_ABCD;
            end
        end
        req_valid = 1'b0;
        check("b2b:stall_cycles", 32'(total_stalls), 32'd2);
        check("b2b:word",         mem[8'h10],        32'hABCD_1234);
        access("b2b_lw", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'hABCD_1234, 0, 0);

        // Reset during the RMW cycle of sb at 0x50 drops the write.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b00;
        req_addr  = 32'h50;
        req_wdata = 32'h0000_0000;
        @(negedge clk);
        check("rst_rmw:read_stall", {31'h0, stall}, 32'h1);
        @(posedge clk);
        #1;
        check("rst_rmw:rmw_we", {31'h0, mem_we}, 32'h1);
        #1;
        reset = 1'b1;
        #1;
        check("rst_rmw:mem_we", {31'h0, mem_we}, 32'h0);
        check("rst_rmw:stall",  {31'h0, stall},  32'h0);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_rmw:stall_after", {31'h0, stall}, 32'h0);
        check("rst_rmw:word",        mem[8'h14],     32'h9988_7766);
        access("rst_rmw_lw", 1'b0, 2'b10, 1'b0, 32'h50, 32'h0, 32'h9988_7766, 0, 0);

`ifdef LSU_MISALIGN_TRAP_EN
        access("sw_61", 1'b1, 2'b10, 1'b0, 32'h61, 32'hCAFE_F00D, 32'h0, 0, 0);
        check("mis:flag",     {31'h0, misalign}, 32'h1);
        check("mis:err_addr", err_addr,          32'h61);
        check("mis:word",     mem[8'h18],        32'h0);
        access("lh_63", 1'b0, 2'b01, 1'b0, 32'h63, 32'h0, 32'h0, 0, 0);
        check("mis:flag2",     {31'h0, misalign}, 32'h1);
        check("mis:err_addr2", err_addr,          32'h61);
`else
        access("sw_61", 1'b1, 2'b10, 1'b0, 32'h61, 32'hCAFE_F00D, 32'h0, 0, 1);
        check("trunc:word",     mem[8'h18],        32'hCAFE_F00D);
        check("trunc:misalign", {31'h0, misalign}, 32'h0);
        check("trunc:err_addr", err_addr,          32'h0);
        access("lh_63", 1'b0, 2'b01, 1'b0, 32'h63, 32'h0, 32'hFFFF_CAFE, 0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
